// File: rtl/stage4_message_assemble_if.sv
// Word-serial feed in, assembled message plus status out, for one message lane.
interface stage4_message_assemble_if #(
  parameter int unsigned MSG_BITS = 512,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned CTRL_W   = 4
);
  logic                in_valid;
  logic                in_sop;
  logic                in_eop;
  logic [DATA_W-1:0]   in_data;
  logic [MSG_BITS-1:0] message;
  logic                message_en;
  logic [CTRL_W-1:0]   message_mux_control;
  logic                err_pulse;
  logic [15:0]         drop_cnt;

  modport master (
    output in_valid, in_sop, in_eop, in_data,
    input  message, message_en, message_mux_control, err_pulse, drop_cnt
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data,
    output message, message_en, message_mux_control, err_pulse, drop_cnt
  );
endinterface

// File: rtl/stage4_message_assemble.sv
// Per-lane message assembler: stages a word-serial message, classifies it by its
// first byte and strobes it out whole; malformed messages are counted and dropped.
module stage4_message_assemble #(
  parameter int unsigned       MSG_BITS = 512,
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       CTRL_W   = 4,
  parameter logic [7:0]        TYPE_Q   = 8'h57,
  parameter logic [7:0]        TYPE_T   = 8'h54,
  parameter logic [CTRL_W-1:0] MUX_Q    = CTRL_W'(1),
  parameter logic [CTRL_W-1:0] MUX_T    = CTRL_W'(2),
  parameter logic [CTRL_W-1:0] MUX_NONE = CTRL_W'(0)
) (
  input  logic                     clk,
  input  logic                     rst,
  stage4_message_assemble_if.slave bus
);

  localparam int unsigned WORDS = MSG_BITS / DATA_W;
  localparam int unsigned IDX_W = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [7:0]          type_q;
  logic [MSG_BITS-1:0] buf_q;
  logic [MSG_BITS-1:0] message_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic                en_q;
  logic                err_q;
  logic [15:0]         cnt_q;

  logic                start;
  logic                cont;
  logic                room;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic                emit;
  logic                discard;
  logic [7:0]          type_d;
  logic [MSG_BITS-1:0] buf_d;
  logic [CTRL_W-1:0]   ctrl_d;

  // Staging-buffer update and event decode for the word on the bus this cycle.
  always_comb begin
    start   = bus.in_valid && bus.in_sop;
    cont    = bus.in_valid && !bus.in_sop && (state_q == COLLECT);
    room    = (idx_q < IDX_W'(WORDS));
    wr_en   = start || (cont && room);
    wr_idx  = start ? '0 : idx_q;
    emit    = wr_en && bus.in_eop;
    discard = (start && (state_q == COLLECT)) || (cont && !room);
    type_d  = start ? bus.in_data[DATA_W-1 -: 8] : type_q;
    buf_d   = start ? '0 : buf_q;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (wr_en && (wr_idx == IDX_W'(k))) begin
        buf_d[MSG_BITS-1-k*DATA_W -: DATA_W] = bus.in_data;
      end
    end
    if (type_d == TYPE_Q)      ctrl_d = MUX_Q;
    else if (type_d == TYPE_T) ctrl_d = MUX_T;
    else                       ctrl_d = MUX_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      type_q    <= '0;
      buf_q     <= '0;
      message_q <= '0;
      ctrl_q    <= MUX_NONE;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      en_q  <= emit;
      err_q <= discard;
      if (discard && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
      if (emit) begin
        message_q <= buf_d;
        ctrl_q    <= ctrl_d;
      end
      if (wr_en) begin
        buf_q  <= buf_d;
        type_q <= type_d;
      end
      // sop restarts from any state; a discard of a partial is flagged above.
      if (start) begin
        idx_q   <= IDX_W'(1);
        state_q <= bus.in_eop ? IDLE : COLLECT;
      end else if (bus.in_valid) begin
        case (state_q)
          COLLECT: begin
            if (room) begin
              idx_q <= idx_q + IDX_W'(1);
              if (bus.in_eop) state_q <= IDLE;
            end else begin
              state_q <= bus.in_eop ? IDLE : DROP;
            end
          end
          DROP:    if (bus.in_eop) state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign bus.message             = message_q;
  assign bus.message_en          = en_q;
  assign bus.message_mux_control = ctrl_q;
  assign bus.err_pulse           = err_q;
  assign bus.drop_cnt            = cnt_q;

endmodule

// File: tb/tb_stage4_message_assemble.sv
// Randomized and directed bench for stage4_message_assemble against a queue-based message model.
module tb_stage4_message_assemble;

  localparam int unsigned MSG_BITS = 512;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned WORDS    = MSG_BITS / DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage4_message_assemble_if bus ();

  stage4_message_assemble dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  // Model: the current message as a queue of words plus whether we are skipping to eop.
  typedef enum int {M_IDLE, M_COLL, M_DROP} mstate_e;
  mstate_e             mstate;
  logic [DATA_W-1:0]   mq[$];
  logic                exp_en, exp_err;
  logic [MSG_BITS-1:0] exp_msg;
  logic [3:0]          exp_ctrl;
  logic [15:0]         exp_cnt;

  function automatic logic [3:0] decode(input logic [7:0] b);
    if (b == 8'h57) return 4'd1;
    if (b == 8'h54) return 4'd2;
    return 4'd0;
  endfunction

  task automatic m_emit();
    logic [MSG_BITS-1:0] m;
    m = '0;
    foreach (mq[k]) m[MSG_BITS-1-k*DATA_W -: DATA_W] = mq[k];
    exp_en   = 1'b1;
    exp_msg  = m;
    exp_ctrl = decode(mq[0][DATA_W-1 -: 8]);
    mstate   = M_IDLE;
  endtask

  task automatic m_discard();
    exp_err = 1'b1;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic model_edge(input bit v, input bit s, input bit e, input logic [DATA_W-1:0] d);
    exp_en  = 1'b0;
    exp_err = 1'b0;
    if (rst) begin
      mstate = M_IDLE; mq.delete(); exp_msg = '0; exp_ctrl = 4'd0; exp_cnt = 16'd0;
    end else if (v) begin
      if (s) begin
        if (mstate == M_COLL) m_discard();
        mq.delete(); mq.push_back(d); mstate = M_COLL;
        if (e) m_emit();
      end else if (mstate == M_COLL) begin
        mq.push_back(d);
        if (mq.size() > WORDS) begin
          m_discard(); mq.delete();
          mstate = e ? M_IDLE : M_DROP;
        end else if (e) begin
          m_emit();
        end
      end else if (mstate == M_DROP) begin
        if (e) mstate = M_IDLE;
      end
    end
  endtask

  task automatic step(input bit v, input bit s, input bit e, input logic [DATA_W-1:0] d);
    bus.in_valid = v; bus.in_sop = s; bus.in_eop = e; bus.in_data = d;
    @(posedge clk);
    model_edge(v, s, e, d);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rword(input logic [7:0] b0);
    logic [DATA_W-1:0] w;
    w = {$urandom, $urandom};
    w[DATA_W-1 -: 8] = b0;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    rst = 1'b0;
    n_chk++; if (bus.message_en !== 1'b0) $display("FAIL reset_en: got %0b want 0", bus.message_en); else n_pass++;
    n_chk++; if (bus.err_pulse !== 1'b0) $display("FAIL reset_err: got %0b want 0", bus.err_pulse); else n_pass++;
    n_chk++; if (bus.message_mux_control !== 4'd0) $display("FAIL reset_ctrl: got %0d want 0", bus.message_mux_control); else n_pass++;
    n_chk++; if (bus.message !== '0) $display("FAIL reset_msg: got %h want 0", bus.message); else n_pass++;
    n_chk++; if (bus.drop_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", bus.drop_cnt); else n_pass++;
    // Partial message cut by a two-cycle reset.
    step(1, 1, 0, rword(8'h57));
    step(1, 0, 0, rword(8'h11));
    step(1, 0, 0, rword(8'h22));
    rst = 1'b1;
    step(1, 0, 0, rword(8'h33));
    step(0, 0, 0, '0);
    rst = 1'b0;
    n_chk++; if (bus.message_en !== 1'b0 || bus.err_pulse !== 1'b0) $display("FAIL midreset_strobes: got en=%0b err=%0b want 0 0", bus.message_en, bus.err_pulse); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      step(1, k == 0, k == 7, rword(k == 0 ? 8'h57 : 8'(k)));
      if (k < 7) begin
        n_chk++; if (bus.message_en !== 1'b0) $display("FAIL post_reset_early_en: got %0b want 0 at word %0d", bus.message_en, k); else n_pass++;
      end
    end
    n_chk++; if (bus.message_en !== 1'b1) $display("FAIL post_reset_en: got %0b want 1", bus.message_en); else n_pass++;
    n_chk++; if (bus.message !== exp_msg) $display("FAIL post_reset_msg: got %h want %h", bus.message, exp_msg); else n_pass++;
    n_chk++; if (bus.drop_cnt !== 16'd0) $display("FAIL post_reset_cnt: got %0d want 0", bus.drop_cnt); else n_pass++;
  endtask

  task automatic test_quote8();
    logic [DATA_W-1:0] w[8];
    for (int k = 0; k < 8; k++) w[k] = {8'h57, 48'h0, 8'(k + 1)};
    step(0, 0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      step(1, k == 0, k == 7, w[k]);
      if (k < 7) begin
        n_chk++; if (bus.message_en !== 1'b0) $display("FAIL q8_early_en: got %0b want 0 at word %0d", bus.message_en, k); else n_pass++;
      end
    end
    n_chk++; if (bus.message_en !== 1'b1) $display("FAIL q8_en: got %0b want 1", bus.message_en); else n_pass++;
    n_chk++; if (bus.message_mux_control !== 4'd1) $display("FAIL q8_ctrl: got %0d want 1", bus.message_mux_control); else n_pass++;
    n_chk++; if (bus.message[511:448] !== w[0]) $display("FAIL q8_word0: got %h want %h", bus.message[511:448], w[0]); else n_pass++;
    n_chk++; if (bus.message[63:0] !== w[7]) $display("FAIL q8_word7: got %h want %h", bus.message[63:0], w[7]); else n_pass++;
    step(0, 0, 0, '0);
    n_chk++; if (bus.message_en !== 1'b0) $display("FAIL q8_en_drop: got %0b want 0", bus.message_en); else n_pass++;
    n_chk++; if (bus.message[63:0] !== w[7] || bus.message_mux_control !== 4'd1) $display("FAIL q8_hold: got %h/%0d want %h/1", bus.message[63:0], bus.message_mux_control, w[7]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w;
    for (int k = 0; k < 3; k++) begin
      w = rword(8'h54);
      step(1, 1, 1, w);
      n_chk++; if (bus.message_en !== 1'b1) $display("FAIL b2b_en: got %0b want 1 at %0d", bus.message_en, k); else n_pass++;
      n_chk++; if (bus.message_mux_control !== 4'd2) $display("FAIL b2b_ctrl: got %0d want 2", bus.message_mux_control); else n_pass++;
      n_chk++; if (bus.message[447:0] !== '0) $display("FAIL b2b_tail: got %h want 0", bus.message[447:0]); else n_pass++;
      n_chk++; if (bus.message[511:448] !== w) $display("FAIL b2b_word0: got %h want %h", bus.message[511:448], w); else n_pass++;
    end
    step(0, 0, 0, '0);
    n_chk++; if (bus.message_en !== 1'b0) $display("FAIL b2b_after: got %0b want 0", bus.message_en); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [MSG_BITS-1:0] held;
    logic [15:0]         cnt0;
    held = exp_msg;
    cnt0 = exp_cnt;
    for (int k = 0; k < 10; k++) begin
      step(1, k == 0, k == 9, rword(8'h57));
      n_chk++; if (bus.err_pulse !== (k == 8)) $display("FAIL ovf_err: got %0b want %0b at word %0d", bus.err_pulse, k == 8, k); else n_pass++;
      n_chk++; if (bus.message_en !== 1'b0) $display("FAIL ovf_en: got %0b want 0 at word %0d", bus.message_en, k); else n_pass++;
    end
    n_chk++; if (bus.drop_cnt !== cnt0 + 16'd1) $display("FAIL ovf_cnt: got %0d want %0d", bus.drop_cnt, cnt0 + 16'd1); else n_pass++;
    n_chk++; if (bus.message !== held) $display("FAIL ovf_hold: got %h want %h", bus.message, held); else n_pass++;
  endtask

  task automatic test_restart();
    logic [DATA_W-1:0] a, b;
    logic [15:0]       cnt0;
    cnt0 = exp_cnt;
    for (int k = 0; k < 4; k++) step(1, k == 0, 0, rword(8'h57));
    a = rword(8'h41);
    b = rword(8'h99);
    step(1, 1, 0, a);
    n_chk++; if (bus.err_pulse !== 1'b1) $display("FAIL rs_err: got %0b want 1", bus.err_pulse); else n_pass++;
    n_chk++; if (bus.drop_cnt !== cnt0 + 16'd1) $display("FAIL rs_cnt: got %0d want %0d", bus.drop_cnt, cnt0 + 16'd1); else n_pass++;
    step(1, 0, 1, b);
    n_chk++; if (bus.message_en !== 1'b1 || bus.err_pulse !== 1'b0) $display("FAIL rs_en: got en=%0b err=%0b want 1 0", bus.message_en, bus.err_pulse); else n_pass++;
    n_chk++; if (bus.message_mux_control !== 4'd0) $display("FAIL rs_ctrl: got %0d want 0", bus.message_mux_control); else n_pass++;
    n_chk++; if (bus.message !== {a, b, 384'h0}) $display("FAIL rs_msg: got %h want %h", bus.message, {a, b, 384'h0}); else n_pass++;
    // sop+eop over a partial: discard and emit surface together.
    step(1, 1, 0, rword(8'h54));
    step(1, 1, 1, rword(8'h54));
    n_chk++; if (bus.message_en !== 1'b1 || bus.err_pulse !== 1'b1) $display("FAIL rs_both: got en=%0b err=%0b want 1 1", bus.message_en, bus.err_pulse); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] b0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: b0 = 8'h57;
        1: b0 = 8'h54;
        2: b0 = 8'h41;
        default: b0 = 8'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, rword(b0));
      n_chk++; if (bus.message_en !== exp_en) $display("FAIL rnd_en: got %0b want %0b cyc %0d", bus.message_en, exp_en, i); else n_pass++;
      n_chk++; if (bus.err_pulse !== exp_err) $display("FAIL rnd_err: got %0b want %0b cyc %0d", bus.err_pulse, exp_err, i); else n_pass++;
      n_chk++; if (bus.message_mux_control !== exp_ctrl) $display("FAIL rnd_ctrl: got %0d want %0d cyc %0d", bus.message_mux_control, exp_ctrl, i); else n_pass++;
      n_chk++; if (bus.message !== exp_msg) $display("FAIL rnd_msg: got %h want %h", bus.message, exp_msg); else n_pass++;
      n_chk++; if (bus.drop_cnt !== exp_cnt) $display("FAIL rnd_cnt: got %0d want %0d cyc %0d", bus.drop_cnt, exp_cnt, i); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    // Each sop over an open partial is one discard, so a stream of sops drives the counter.
    for (int i = 0; i < 65540; i++) step(1, 1, 0, rword(8'h57));
    n_chk++; if (bus.drop_cnt !== 16'hFFFF) $display("FAIL sat_cnt: got %h want ffff", bus.drop_cnt); else n_pass++;
    n_chk++; if (bus.drop_cnt !== exp_cnt) $display("FAIL sat_model: got %h want %h", bus.drop_cnt, exp_cnt); else n_pass++;
    n_chk++; if (bus.err_pulse !== 1'b1) $display("FAIL sat_err: got %0b want 1", bus.err_pulse); else n_pass++;
    step(1, 1, 1, rword(8'h54));
    n_chk++; if (bus.drop_cnt !== 16'hFFFF || bus.message_en !== 1'b1) $display("FAIL sat_final: got cnt=%h en=%0b want ffff 1", bus.drop_cnt, bus.message_en); else n_pass++;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_data = '0;
    mstate = M_IDLE; exp_en = 1'b0; exp_err = 1'b0; exp_msg = '0; exp_ctrl = 4'd0; exp_cnt = 16'd0;
    test_reset();
    test_quote8();
    test_back_to_back();
    test_overflow();
    test_restart();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
